alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, the iteration-counter width.
REQ-003 The block SHALL have port clk_i  input  1  clock; the single clock, rising-edge.
REQ-004 The block SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port start_i  input  1  operation request, accepted only when ready_o=1.
REQ-006 The block SHALL have port kill_i  input  1  abort the in-flight operation.
REQ-007 The block SHALL have port funct_i  input  6  R-type function field.
REQ-008 The block SHALL have port ALUOp_i  input  2  main-decoder op class.
REQ-009 The block SHALL have ports src1_i and src2_i  input  WIDTH  operands.
REQ-010 The block SHALL have port ready_o  output  1  idle and able to accept.
REQ-011 The block SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-012 The block SHALL have ports result_o and hi_o  output  WIDTH  low and high results.
REQ-013 The block SHALL have port zero_o  output  1  result_o==0, qualified by valid_o.

Function
REQ-014 Decode SHALL be: ALUOp_i=1 -> ADD; ALUOp_i=2 -> SUB; ALUOp_i=0 or 3 -> funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 011000 MUL, any other -> NOP.
REQ-015 The FSM SHALL have states IDLE and ITER; ready_o=1 exactly in IDLE.
REQ-016 Request acceptance SHALL be start_i=1 and ready_o=1 at a rising edge; start_i outside IDLE SHALL be ignored without queuing.
REQ-017 ADD/SUB/AND/OR SHALL have latency 1: at the accept edge, result_o is loaded, hi_o=0, and valid_o=1 for the next cycle; the FSM stays in IDLE.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-019 NOP SHALL give latency 1 with result_o=0 and hi_o=0.
REQ-020 MUL SHALL be unsigned radix-2 shift-add: the accept edge moves the FSM to ITER with counter=WIDTH; each ITER edge decrements the counter; the edge at which the counter reaches 0 loads {hi_o,result_o}=src1*src2 (2*WIDTH bits), asserts valid_o, and returns the FSM to IDLE; accept-to-valid latency SHALL be WIDTH+1 edges.
REQ-021 Operands SHALL be captured at acceptance; input changes during ITER SHALL have no effect.
REQ-022 valid_o SHALL be high for exactly one cycle per completed operation; result_o, hi_o, and zero_o SHALL hold their values until the next completion.
REQ-023 kill_i=1 SHALL dominate start_i: in ITER it returns the FSM to IDLE next edge with no valid_o; in IDLE it blocks acceptance; result_o and hi_o SHALL remain unchanged.
REQ-024 A new request SHALL be acceptable in the same cycle valid_o is high, giving back-to-back 1-cycle ops at full throughput.

Reset
REQ-025 rst_i=1 SHALL asynchronously force: FSM=IDLE, counter=0, ready_o=1 (after release), valid_o=0, result_o=0, hi_o=0, zero_o=1.
REQ-026 Reset during ITER SHALL discard the operation with no valid_o after release.

Configuration
REQ-027 With macro ALU_MULTICYCLE_DIV_EN defined, funct 011010 SHALL decode to DIV: unsigned restoring division with the same ITER timing as MUL, result_o=quotient, and hi_o=remainder.
REQ-028 With ALU_MULTICYCLE_DIV_EN defined, DIV with src2=0 SHALL complete in 1 cycle with result_o=all ones and hi_o=src1.
REQ-029 Without ALU_MULTICYCLE_DIV_EN, funct 011010 SHALL decode to NOP and no divider logic SHALL be present.

Structure
REQ-030 Shared package alu_pkg SHALL hold the ALU control encoding (NOP=0, ADD=1, SUB=2, AND=3, OR=4, MUL=5, DIV=6; 3 bits) and the funct code constants.
REQ-031 The iterative datapath (shift-add multiply, restoring divide, counter) SHALL be sub-module alu_iter_muldiv; the FSM, decode, and 1-cycle ops SHALL stay in the top module.

Verification
REQ-032 The bench SHALL cover: WIDTH=32, ALUOp=0, funct=100010, src1=5, src2=7, start -> next cycle valid_o=1, result_o=32'hFFFFFFFE, zero_o=0.
REQ-033 The bench SHALL cover: MUL, src1=32'hFFFFFFFF, src2=2 -> valid_o exactly 33 edges after accept, hi_o=1, result_o=32'hFFFFFFFE, ready_o=0 in between.
REQ-034 The bench SHALL cover: MUL in flight, start_i pulsed with ADD at cycle 5 -> ignored, only the MUL result is delivered.
REQ-035 The bench SHALL cover: MUL in flight, kill_i at cycle 10 -> ready_o=1 next cycle, no valid_o, result_o unchanged; then ADD 3+4 -> result_o=7.
REQ-036 The bench SHALL cover: rst_i asserted mid-MUL -> all outputs reach reset values immediately without a clock edge; no valid_o after release.
REQ-037 The bench SHALL cover, with DIV_EN and WIDTH=16: DIV 100/7 -> result_o=14, hi_o=2 at 17 edges; DIV 9/0 -> result_o=16'hFFFF, hi_o=9 at 1 edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encoding, R-type funct codes, FSM states
// and the main/funct decoder.
// Optional feature macro: ALU_MULTICYCLE_DIV_EN (enables the DIV funct code).
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_MUL = 3'd5,
        ALU_DIV = 3'd6
    } alu_ctrl_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    // Main-decoder op class 1/2 force ADD/SUB; 0 and 3 defer to the funct field.
    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                             input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_NOP;
        case (alu_op)
            2'd1:    ctrl = ALU_ADD;
            2'd2:    ctrl = ALU_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_MUL: ctrl = ALU_MUL;
`ifdef ALU_MULTICYCLE_DIV_EN
                    FUNCT_DIV: ctrl = ALU_DIV;
`endif
                    default:   ctrl = ALU_NOP;
                endcase
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: unsigned radix-2 shift-add multiplier, optional
// restoring divider (macro ALU_MULTICYCLE_DIV_EN) and the iteration counter.
// hi_next_o/lo_next_o expose the value the next step will produce so the
// owner can capture the final step without an extra cycle.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             kill_i,
`ifdef ALU_MULTICYCLE_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] hi_next_o,
    output logic [WIDTH-1:0] lo_next_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_MULTICYCLE_DIV_EN
    logic             is_div_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
`endif

    assign count_o = count_q;

    // One iteration step: add-then-shift-right for MUL, shift-left-then-trial-subtract for DIV.
    always_comb begin
        // NOTE: every output of this block is assigned before any branch so no latch is inferred.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_next_o = mul_sum[WIDTH:1];
        lo_next_o = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_MULTICYCLE_DIV_EN
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            if (rem_shift >= {1'b0, b_q}) begin
                hi_next_o = rem_diff;
                lo_next_o = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_next_o = rem_shift[WIDTH-1:0];
                lo_next_o = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Operand capture at acceptance, then one step per cycle while the counter runs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            count_q  <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else if (start_i) begin
            hi_q     <= '0;
            lo_q     <= a_i;
            b_q      <= b_i;
            count_q  <= CNT_W'(WIDTH);
`ifdef ALU_MULTICYCLE_DIV_EN
            is_div_q <= is_div_i;
`endif
        end else if (kill_i) begin
            count_q  <= '0;
        end else if (count_q != '0) begin
            hi_q     <= hi_next_o;
            lo_q     <= lo_next_o;
            count_q  <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: decode, IDLE/ITER control FSM and single-cycle ops.
// MUL (and DIV when macro ALU_MULTICYCLE_DIV_EN is defined) run in the
// iterative sub-module; every other op completes one edge after acceptance.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic [5:0]       funct_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o
);

    state_e           state_q, state_d;
    alu_ctrl_e        ctrl;
    logic             accept;
    logic             iter_op;
    logic             iter_start;
    logic             iter_done;
    logic             iter_kill;
    logic [CNT_W-1:0] iter_count;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] quick_res, quick_hi;

    assign ctrl      = alu_decode(ALUOp_i, funct_i);
    assign ready_o   = (state_q == S_IDLE);
    assign accept    = ready_o && start_i && !kill_i;
    assign iter_kill = (state_q == S_ITER) && kill_i;
    assign iter_done = (state_q == S_ITER) && !kill_i && (iter_count == CNT_W'(1));
`ifdef ALU_MULTICYCLE_DIV_EN
    // Divide by zero short-circuits to the single-cycle path.
    assign iter_op   = (ctrl == ALU_MUL) || ((ctrl == ALU_DIV) && (src2_i != '0));
`else
    assign iter_op   = (ctrl == ALU_MUL);
`endif

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (iter_start),
        .kill_i    (iter_kill),
`ifdef ALU_MULTICYCLE_DIV_EN
        .is_div_i  (ctrl == ALU_DIV),
`endif
        .a_i       (src1_i),
        .b_i       (src2_i),
        .count_o   (iter_count),
        .hi_next_o (iter_hi),
        .lo_next_o (iter_lo)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and iteration launch; kill wins over the final step.
    always_comb begin
        state_d    = state_q;
        iter_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && iter_op) begin
                    state_d    = S_ITER;
                    iter_start = 1'b1;
                end
            end
            S_ITER: begin
                if (kill_i || (iter_count == CNT_W'(1))) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle results, including the divide-by-zero shortcut.
    always_comb begin
        quick_res = '0;
        quick_hi  = '0;
        case (ctrl)
            ALU_ADD: quick_res = src1_i + src2_i;
            ALU_SUB: quick_res = src1_i - src2_i;
            ALU_AND: quick_res = src1_i & src2_i;
            ALU_OR:  quick_res = src1_i | src2_i;
`ifdef ALU_MULTICYCLE_DIV_EN
            ALU_DIV: begin
                quick_res = '1;
                quick_hi  = src1_i;
            end
`endif
            default: ;
        endcase
    end

    // Output registers: load on completion, hold otherwise; valid is a one-cycle strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            hi_o     <= '0;
            zero_o   <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            if (accept && !iter_op) begin
                valid_o  <= 1'b1;
                result_o <= quick_res;
                hi_o     <= quick_hi;
                zero_o   <= (quick_res == '0);
            end else if (iter_done) begin
                valid_o  <= 1'b1;
                result_o <= iter_lo;
                hi_o     <= iter_hi;
                zero_o   <= (iter_lo == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle. Default build runs WIDTH=32; with
// ALU_MULTICYCLE_DIV_EN defined it runs WIDTH=16 and exercises DIV.
module tb_alu_multicycle;

`ifdef ALU_MULTICYCLE_DIV_EN
    localparam int W = 16;
`else
    localparam int W = 32;
`endif
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, kill;
    logic [5:0]   funct;
    logic [1:0]   alu_op;
    logic [W-1:0] src1, src2;
    logic         ready, valid, zero;
    logic [W-1:0] result, hi;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .kill_i   (kill),
        .funct_i  (funct),
        .ALUOp_i  (alu_op),
        .src1_i   (src1),
        .src2_i   (src2),
        .ready_o  (ready),
        .valid_o  (valid),
        .result_o (result),
        .hi_o     (hi),
        .zero_o   (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected entry, on its due cycle.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got result %h at cycle %0d, expected no valid", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".cycle"},  64'(cyc),    64'(e.due));
                check({e.name, ".result"}, 64'(result), 64'(e.res));
                check({e.name, ".hi"},     64'(hi),     64'(e.hi));
                check({e.name, ".zero"},   64'(zero),   64'(e.res == '0));
            end
        end
    end

    // Called at a negedge: drives one request for one cycle; lat counts the accept edge as edge 1.
    task automatic issue(input string name, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                         input logic [W-1:0] er, input logic [W-1:0] eh, input int lat);
        start  = 1'b1;
        alu_op = op;
        funct  = f;
        src1   = a;
        src2   = b;
        if (push) begin
            sb.push_back('{name, er, eh, cyc + lat});
            last_res = er;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        funct = '0; alu_op = '0; src1 = '0; src2 = '0;
        repeat (2) @(negedge clk);
        check("reset.ready",  64'(ready),  64'(1));
        check("reset.valid",  64'(valid),  64'(0));
        check("reset.result", 64'(result), 64'(0));
        check("reset.hi",     64'(hi),     64'(0));
        check("reset.zero",   64'(zero),   64'(1));
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops issued back to back at full throughput.
        issue("sub_5_7",  2'd0, 6'b100010, 5, 7, 1, ONES - 1, '0, 1);
        issue("aluop_add", 2'd1, 6'b000000, 100, 23, 1, 123, '0, 1);
        issue("aluop_sub", 2'd2, 6'b100101, 50, 8, 1, 42, '0, 1);
        issue("add_wrap", 2'd0, 6'b100000, ONES, 1, 1, '0, '0, 1);
        issue("and",      2'd3, 6'b100100, 'hF0F0, 'h0FF0, 1, 'h00F0, '0, 1);
        issue("or",       2'd0, 6'b100101, 'hF0F0, 'h0F0F, 1, 'hFFFF, '0, 1);
        issue("nop",      2'd0, 6'b111111, 9, 9, 1, '0, '0, 1);
`ifdef ALU_MULTICYCLE_DIV_EN
        issue("div_by_0", 2'd0, 6'b011010, 9, 0, 1, ONES, 9, 1);
`else
        issue("div_nop",  2'd0, 6'b011010, 100, 7, 1, '0, '0, 1);
`endif
        drain(10);

        // MUL with a nonzero high half; ready must stay low while iterating.
        issue("mul_ones_x2", 2'd0, 6'b011000, ONES, 2, 1, ONES - 1, 1, W + 1);
        for (int i = 0; i < W; i++) begin
            check("mul_busy.ready", 64'(ready), 64'(0));
            @(negedge clk);
        end
        check("mul_done.ready", 64'(ready), 64'(1));
        drain(5);
        issue("mul_ones_sq", 2'd0, 6'b011000, ONES, ONES, 1, 1, ONES - 1, W + 1);
        drain(W + 5);

`ifdef ALU_MULTICYCLE_DIV_EN
        issue("div_100_7", 2'd0, 6'b011010, 100, 7, 1, 14, 2, W + 1);
        drain(W + 5);
`endif

        // A start during ITER, with new operands, must be ignored entirely.
        issue("mul_171_205", 2'd0, 6'b011000, 171, 205, 1, 'h88EF, '0, W + 1);
        repeat (4) @(negedge clk);
        issue("ignored_add", 2'd1, 6'b100000, 1, 1, 0, '0, '0, 1);
        src1 = 3; src2 = 3;
        drain(W + 5);

        // Kill mid-MUL: back to IDLE next edge, no valid, outputs hold.
        issue("mul_killed", 2'd0, 6'b011000, ONES, ONES, 0, '0, '0, 0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill.ready",  64'(ready),  64'(1));
        check("kill.valid",  64'(valid),  64'(0));
        check("kill.result", 64'(result), 64'(last_res));
        // Kill in IDLE blocks acceptance.
        kill = 1'b1;
        issue("blocked_add", 2'd1, 6'b100000, 1, 2, 0, '0, '0, 1);
        kill = 1'b0;
        check("kill_idle.ready",  64'(ready),  64'(1));
        check("kill_idle.result", 64'(result), 64'(last_res));
        repeat (W + 3) @(negedge clk);
        issue("add_3_4", 2'd0, 6'b100000, 3, 4, 1, 7, '0, 1);
        drain(5);

        // Asynchronous reset mid-MUL: outputs clear without a clock edge.
        issue("mul_reset", 2'd0, 6'b011000, ONES, 3, 0, '0, '0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst.ready",  64'(ready),  64'(1));
        check("async_rst.valid",  64'(valid),  64'(0));
        check("async_rst.result", 64'(result), 64'(0));
        check("async_rst.hi",     64'(hi),     64'(0));
        check("async_rst.zero",   64'(zero),   64'(1));
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("post_rst.valid", 64'(valid), 64'(0));
        issue("post_rst_add", 2'd1, 6'b000000, 40, 2, 1, 42, '0, 1);
        drain(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
